// File: rtl/tmr0_prescaler_if.sv
// Register-file write bus snooped by Timer0: strobe, target address and ALU result.
interface tmr0_prescaler_if;
   logic       write_enable;
   logic [6:0] register_address;
   logic [7:0] write_data;

   modport master (output write_enable, output register_address, output write_data);
   modport slave  (input  write_enable, input  register_address, input  write_data);
endinterface

// File: rtl/tmr0_prescaler.sv
// PIC16F84 Timer0: TMR0/OPTION write decode, edge-synchronised T0CKI, 8-bit prescaler, sticky T0IF.
// Optional interrupt output (t0ie/irq) is built only when TMR0_IRQ_EN is defined.
//
// state | meaning
// IDLE  | counting normally
// INH1  | first cycle after a TMR0 write, ticks discarded
// INH2  | second cycle after a TMR0 write, ticks discarded
module tmr0_prescaler #(
   parameter logic [6:0] TMR0_ADDR    = 7'h01,
   parameter logic [6:0] OPTION_ADDR  = 7'h41,
   parameter logic [7:0] OPTION_RESET = 8'hFF
) (
   input  logic                  clk_registers,
   input  logic                  reset,
   tmr0_prescaler_if.slave       bus,
   input  logic                  t0cki,
   input  logic                  t0if_clear,
   output logic [7:0]            tmr0_out,
   output logic [7:0]            option_out,
   output logic                  t0if
`ifdef TMR0_IRQ_EN
   ,
   input  logic                  t0ie,
   output logic                  irq
`endif
);

   typedef enum logic [1:0] {IDLE, INH1, INH2} state_t;

   state_t     state;
   logic [7:0] ps_count;
   logic       sync1;
   logic       sync2;
   logic       prev;

   logic       wr_tmr0;
   logic       wr_option;
   logic       edge_tick;
   logic       tick;
   logic       ps_wrap;
   logic       inc;
   logic [7:0] ps_limit;

   always_comb begin
      wr_tmr0   = bus.write_enable && (bus.register_address == TMR0_ADDR);
      wr_option = bus.write_enable && (bus.register_address == OPTION_ADDR);
      edge_tick = option_out[4] ? (~sync2 & prev) : (sync2 & ~prev);
      tick      = option_out[5] ? edge_tick : 1'b1;
      // ratio 2^(PS+1); PS=7 gives 256, whose terminal count 255 still fits 8 bits
      ps_limit  = 8'((9'd2 << option_out[2:0]) - 9'd1);
      ps_wrap   = (ps_count == ps_limit);
      inc       = tick && (state == IDLE) && (option_out[3] || ps_wrap);
   end

   always_ff @(posedge clk_registers) begin
      if (reset) begin
         state      <= IDLE;
         tmr0_out   <= 8'h00;
         option_out <= OPTION_RESET;
         t0if       <= 1'b0;
         ps_count   <= 8'h00;
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         prev       <= 1'b0;
      end else begin
         sync1 <= t0cki;
         sync2 <= sync1;
         prev  <= sync2;

         if (t0if_clear)
            t0if <= 1'b0;

         if (wr_tmr0) begin
            tmr0_out <= bus.write_data;
            ps_count <= 8'h00;
            state    <= INH1;
         end else begin
            case (state)
               INH1:    state <= INH2;
               INH2:    state <= IDLE;
               default: state <= IDLE;
            endcase
            if (inc) begin
               tmr0_out <= tmr0_out + 8'd1;
               if (tmr0_out == 8'hFF)
                  t0if <= 1'b1;
            end
            if (tick && (state == IDLE) && !option_out[3])
               ps_count <= ps_wrap ? 8'h00 : ps_count + 8'd1;
         end

         // Mode change restarts the prescale phase; sync chain is left running.
         if (wr_option) begin
            option_out <= bus.write_data;
            ps_count   <= 8'h00;
         end
      end
   end

`ifdef TMR0_IRQ_EN
   always_ff @(posedge clk_registers) begin
      if (reset)
         irq <= 1'b0;
      else
         irq <= t0if & t0ie;
   end
`endif

endmodule

// File: doc/tmr0_prescaler.md
Name: tmr0_prescaler

Overview:
- Timer0 peripheral for the PIC16F84 core, directly downstream of the register-file write path.
- Snoops the same write strobe, address and ALU-result bus that feed `registers`.
- Decodes writes to its TMR0 and OPTION addresses.
- Counts instruction-clock or external T0CKI events through an 8-bit programmable prescaler.
- Raises a sticky T0IF flag on TMR0 overflow.

Parameters:
- TMR0_ADDR, 7'h01, register-file address of TMR0.
- OPTION_ADDR, 7'h41, register-file address of OPTION (flat map, no bank bit).
- OPTION_RESET, 8'hFF, OPTION value loaded on reset.

Ports:
- clk_registers  input  1  register-stage clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- write_enable  input  1  register-file write strobe for the current cycle.
- register_address  input  7  target address of the write.
- write_data  input  8  ALU result being written.
- t0cki  input  1  external timer clock pin, asynchronous.
- t0if_clear  input  1  one-cycle pulse clearing T0IF.
- tmr0_out  output  8  current TMR0 value.
- option_out  output  8  current OPTION value.
- t0if  output  1  sticky overflow flag.

Behaviour:
- Interface: one clock (clk_registers); reset is synchronous and active-high.
- Reset values:
  - tmr0_out=0x00, option_out=OPTION_RESET, t0if=0.
  - Prescaler count=0; sync flops=0; inhibit FSM=IDLE.
- OPTION fields:
  - [5] T0CS: 0 = internal clock, 1 = external.
  - [4] T0SE: 0 = rising edge, 1 = falling edge.
  - [3] PSA: 1 = prescaler bypassed (1:1).
  - [2:0] PS: ratio 2^(PS+1), i.e. 2..256.
  - Bits [7:6] are stored and read back but are otherwise unused.
- Tick source:
  - T0CS=0: a tick every clock.
  - T0CS=1: t0cki passes through 2-flop synchroniser sync1, sync2, then a prev flop.
  - Tick = sync2&~prev when T0SE=0; ~sync2&prev when T0SE=1.
  - A pin edge settling before clock edge k updates TMR0 at edge k+2.
- Prescaler:
  - PSA=1: each tick is an increment; prescaler count is held at 0.
  - PSA=0: on each tick, count increments. When count == ratio-1, count returns to 0 and an increment is issued.
  - Count is 8 bits wide, so ratio 256 compares to 255.
- Increment: tmr0 <= tmr0+1, modulo 256. 0xFF->0x00 sets t0if at that same edge.
- TMR0 write (write_enable & register_address==TMR0_ADDR):
  - tmr0 <= write_data; prescaler count <= 0.
  - The FSM goes to INH1, then INH2, then IDLE.
  - In INH1 and INH2, ticks are discarded and the count stays 0. The first possible increment is the 3rd edge after the write edge.
  - A TMR0 write during INH1 or INH2 reloads and restarts at INH1.
- OPTION write:
  - option <= write_data; prescaler count <= 0.
  - No inhibit; the new mode applies from the next edge.
  - Sync flops keep running so that a T0CS change cannot fabricate a tick.
- Writes to any other address are ignored.
- Simultaneous events:
  - TMR0 write and increment in the same cycle: the write wins; no overflow and no t0if set.
  - Overflow and t0if_clear in the same cycle: the set wins (t0if=1).
- t0if stays at 1 until t0if_clear or reset. A TMR0 write does not clear it.
- Reset asserted mid-count or during inhibit returns every register to its reset value at that edge; reset overrides all writes.

Optional Feature:
- Macro: TMR0_IRQ_EN.
- Defined:
  - Adds input t0ie (1 bit) and output irq (1 bit).
  - irq is registered: irq <= t0if & t0ie, one cycle after t0if. It is cleared on reset.
  - irq drops the cycle after t0if clears or t0ie falls.
- Undefined: neither port exists and there is no irq logic. All other behaviour is identical.

Test Plan:
- Reset check: hold reset 2 cycles -> tmr0_out=0x00, option_out=0xFF, t0if=0. With T0CS=1, toggling t0cki during reset leaves tmr0_out at 0.
- Internal, 1:1 and inhibit: write OPTION=0x08 (internal, PSA=1), then write TMR0=0xFD at edge n.
  - Required: tmr0_out=0xFD through edge n+2; 0xFE at n+3; 0xFF at n+4; 0x00 with t0if=1 at n+5.
- Prescale 1:4: OPTION=0x01, TMR0=0x10 at edge n.
  - Required: tmr0_out=0x11 at n+6 and 0x12 at n+10.
  - Rewriting OPTION=0x01 at n+8 clears the count, so the next increment moves to n+12.
- External, falling edge: OPTION=0x38, TMR0=0x00, then 3 falling t0cki pulses, each 4 clocks wide.
  - Required: tmr0_out=0x03; each step lands 2 edges after the pin edge.
  - Rising-only pulses produce no change.
- Collisions:
  - TMR0=0xFF in internal 1:1; write TMR0=0x80 on the edge that would overflow -> tmr0_out=0x80 and t0if stays 0.
  - Force an overflow with t0if_clear high in the same cycle -> t0if=1.
- TMR0_IRQ_EN: t0ie=1, force an overflow -> irq=1 one edge after t0if. Pulse t0if_clear -> irq=0 one edge after t0if falls.
